multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Finite-state controller that runs the single-issue core as a multi-cycle machine.
- Sequences fetch, decode, execute, memory and writeback, and generates all register and memory enables around the execute datapath.
- Stalls for an iterative multiplier and for request/acknowledge instruction and data memories, with timeout error detection.
- Sits beside the execute stage; the decoder supplies the instruction class and the ALU supplies the eq flag.

Parameters:
- MUL_CYCLES, 4: cycles spent in MUL_WAIT; legal range 1..31.
- MEM_TIMEOUT, 16: maximum request cycles without an ack before ERROR; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  level; leaves IDLE.
- op_class  in  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 MUL, 4 BRANCH, 5 JAL, 6 HALT, 7 illegal.
- eq  in  1  ALU compare result; valid in EXEC.
- imem_ack  in  1  instruction memory acknowledge.
- dmem_ack  in  1  data memory acknowledge.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register load.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write qualifier.
- md_we  out  1  load-data register capture.
- rf_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_sel  out  1  0 = pc+4, 1 = jal_br_target.
- mul_busy  out  1  high in MUL_WAIT.
- busy  out  1  high in every state except IDLE, HALT, ERROR.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.
- retired  out  32  retired-instruction count; see Optional Feature.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MUL_WAIT, MEM, WB, HALT, ERROR.
- Outputs are decoded from the state, except ir_we and md_we.
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE; op_q = 0; eq_q = 0; tmo_cnt = 0; mul_cnt = 0.
  - Every output is 0 while rst_n is low and in IDLE.
  - An outstanding memory request is dropped with no completion.
- IDLE: start = 1 -> FETCH.
- FETCH:
  - imem_req = 1.
  - ir_we = imem_ack (same cycle).
  - imem_ack -> DECODE.
- DECODE:
  - op_q <= op_class.
  - Class 6 -> HALT; class 7 -> ERROR; class 3 -> MUL_WAIT (mul_cnt <= MUL_CYCLES-1); else -> EXEC.
- EXEC:
  - eq_q <= eq.
  - LOAD or STORE -> MEM; otherwise -> WB.
- MUL_WAIT:
  - mul_busy = 1.
  - mul_cnt decrements each cycle; at 0 -> WB.
  - Occupancy is exactly MUL_CYCLES cycles.
- MEM:
  - dmem_req = 1; dmem_we = (op_q == STORE).
  - md_we = dmem_ack & (op_q == LOAD).
  - dmem_ack -> WB.
- WB:
  - pc_we = 1.
  - rf_we = op_q in {ALU, LOAD, MUL, JAL}.
  - pc_sel = (op_q == JAL) | (op_q == BRANCH & eq_q).
  - Next state is FETCH (start is ignored once running).
- Timeout:
  - tmo_cnt clears on entry to FETCH or MEM.
  - It increments each request cycle without an ack.
  - If the ack is absent when tmo_cnt == MEM_TIMEOUT-1 -> ERROR.
  - An ack in the MEM_TIMEOUT-th request cycle is accepted.
- HALT and ERROR are sticky until reset. busy = 0 in both; halted = 1 in HALT only; err = 1 in ERROR only.
- Latency with a same-cycle ack:
  - ALU, BRANCH, JAL: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD, STORE: 5 cycles.
  - MUL: 3 + MUL_CYCLES cycles.
- An ack arriving while its request is low is ignored.
- pc_we and rf_we are never high outside WB.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - retired is a 32-bit counter, reset to 0.
  - It increments by 1 in every WB cycle and wraps from 0xFFFFFFFF to 0.
  - HALT instructions are not counted.
- Undefined: retired is tied to 0 and no counter flops are synthesised.

Test Plan:
- ALU run: start = 1, op_class = 0, imem_ack in the first FETCH cycle -> states FETCH, DECODE, EXEC, WB; rf_we = 1 and pc_we = 1 in cycle 4; pc_sel = 0; next cycle is FETCH.
- BRANCH: op_class = 4 with eq = 1 in EXEC -> pc_sel = 1 in WB. Repeat with eq = 0 -> pc_sel = 0. rf_we = 0 in both runs.
- LOAD with dmem_ack delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we = 0.
  - md_we pulses on the ack cycle.
  - rf_we = 1 in the following WB.
  - Total 8 cycles.
- MUL, MUL_CYCLES = 4: mul_busy high exactly 4 cycles; WB on cycle 7 with rf_we = 1.
- Timeout, MEM_TIMEOUT = 16:
  - imem_ack never asserted -> imem_req high 16 cycles, then ERROR with err = 1 and busy = 0; err persists with start = 1.
  - An ack in request cycle 16 proceeds to DECODE instead.
- Reset mid-MEM: rst_n low while dmem_req = 1 -> dmem_req = 0 immediately, state IDLE; with PERF_CNT_EN defined, retired = 0, and 3 ALU instructions then retired = 3.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the single-issue core.
// Walks each instruction through fetch, decode, execute, memory and writeback,
// and raises the register and memory enables around the execute datapath.
// It stalls for the iterative multiplier and for request/acknowledge
// instruction and data memories, and flags an error on a memory timeout.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,   // 1..31 cycles spent in MUL_WAIT
  parameter int unsigned MEM_TIMEOUT = 16   // 1..255 request cycles before ERROR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op_class,
  input  logic        eq,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        md_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        mul_busy,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  // Decoded instruction classes as supplied by the decoder.
  localparam logic [2:0] OpAlu    = 3'd0;
  localparam logic [2:0] OpLoad   = 3'd1;
  localparam logic [2:0] OpStore  = 3'd2;
  localparam logic [2:0] OpMul    = 3'd3;
  localparam logic [2:0] OpBranch = 3'd4;
  localparam logic [2:0] OpJal    = 3'd5;
  localparam logic [2:0] OpHalt   = 3'd6;
  localparam logic [2:0] OpIll    = 3'd7;

  // Counter reload / terminal values, sized to the counter registers.
  localparam logic [4:0] MulLoad = 5'(MUL_CYCLES - 1);
  localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMulWait,
    StMem,
    StWb,
    StHalt,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       eq_q, eq_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [4:0] mul_cnt_q, mul_cnt_d;

  // State and datapath-side registers; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= 3'd0;
      eq_q      <= 1'b0;
      tmo_cnt_q <= 8'd0;
      mul_cnt_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      eq_q      <= eq_d;
      tmo_cnt_q <= tmo_cnt_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Next-state logic, including the timeout and multiplier counters.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    eq_d      = eq_q;
    tmo_cnt_d = tmo_cnt_q;
    mul_cnt_d = mul_cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          tmo_cnt_d = 8'd0;
        end
      end

      StFetch: begin
        if (imem_ack) begin
          state_d = StDecode;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d = StError;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      StDecode: begin
        op_d = op_class;
        case (op_class)
          OpHalt:  state_d = StHalt;
          OpIll:   state_d = StError;
          OpMul: begin
            state_d   = StMulWait;
            mul_cnt_d = MulLoad;
          end
          default: state_d = StExec;
        endcase
      end

      StExec: begin
        eq_d = eq;
        if (op_q == OpLoad || op_q == OpStore) begin
          state_d   = StMem;
          tmo_cnt_d = 8'd0;
        end else begin
          state_d = StWb;
        end
      end

      StMulWait: begin
        // Entered with MUL_CYCLES-1 so the stall lasts exactly MUL_CYCLES.
        if (mul_cnt_q == 5'd0) begin
          state_d = StWb;
        end else begin
          mul_cnt_d = mul_cnt_q - 5'd1;
        end
      end

      StMem: begin
        if (dmem_ack) begin
          state_d = StWb;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d = StError;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      StWb: begin
        // Once running, start is ignored and the next instruction is fetched.
        state_d   = StFetch;
        tmo_cnt_d = 8'd0;
      end

      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: state-only except the same-cycle ack-qualified captures.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    md_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    mul_busy = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;

    case (state_q)
      StFetch: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      StDecode: busy = 1'b1;
      StExec:   busy = 1'b1;
      StMulWait: begin
        busy     = 1'b1;
        mul_busy = 1'b1;
      end
      StMem: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op_q == OpStore);
        md_we    = dmem_ack & (op_q == OpLoad);
      end
      StWb: begin
        busy   = 1'b1;
        pc_we  = 1'b1;
        rf_we  = (op_q == OpAlu) || (op_q == OpLoad) || (op_q == OpMul) || (op_q == OpJal);
        pc_sel = (op_q == OpJal) || ((op_q == OpBranch) && eq_q);
      end
      StHalt:  halted = 1'b1;
      StError: err    = 1'b1;
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] retired_q;

  // Count one retired instruction per writeback; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else if (state_q == StWb) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

endmodule
